// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and address helpers for the LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_IDLE,
        S_ADDR,
        S_DATA
    } lcd_state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_PULSE,
        X_WAIT
    } xfer_phase_e;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW1_OFFSET   = 8'h40;

    // Row/column to DDRAM address; bits [7:5] of the request are dropped.
    function automatic logic [7:0] ddram_addr(input logic [7:0] address);
        return (address[4] ? ROW1_OFFSET : 8'h00) | {4'h0, address[3:0]};
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = CMD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// One LCD bus byte: SETUP (EN low), PULSE (EN high), WAIT (EN low), then a done pulse.
// RS/DATA are latched on go and held through all three phases.
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int EN_PULSE_CYCLES   = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_long_wait,
    output logic       o_done,
    output logic       o_en,
    output logic       o_rs,
    output logic [7:0] o_data
);

    localparam int MAX_A    = (CLEAR_WAIT_CYCLES > CMD_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_LOAD = (MAX_A > EN_PULSE_CYCLES) ? MAX_A : EN_PULSE_CYCLES;
    localparam int CNT_W    = $clog2(MAX_LOAD + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(EN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    xfer_phase_e      phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_q, long_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             tc;

    assign tc = (cnt_q == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= X_IDLE;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        long_d  = long_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (phase_q)
            X_SETUP: begin
                if (tc) begin
                    phase_d = X_PULSE;
                    cnt_d   = PULSE_LOAD;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            X_PULSE: begin
                if (tc) begin
                    phase_d = X_WAIT;
                    cnt_d   = long_q ? CLEAR_LOAD : CMD_LOAD;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            X_WAIT: begin
                if (tc) begin
                    phase_d = X_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
        // A new byte may start in the last WAIT cycle, so bytes run back to back.
        if (i_go) begin
            phase_d = X_SETUP;
            cnt_d   = PULSE_LOAD;
            long_d  = i_long_wait;
            en_d    = 1'b0;
            rs_d    = i_rs;
            data_d  = i_data;
        end
    end

    assign o_done = (phase_q == X_WAIT) && tc;
    assign o_en   = en_q;
    assign o_rs   = rs_q;
    assign o_data = data_q;

endmodule

// File: rtl/lcd_controller.sv
// HD44780 16x2 LCD controller: power-up wait, init sequence, then address + data writes.
// Optional macro LCD_ADDR_SKIP_EN skips the address byte when the cursor is already in place.
//
//   state     | meaning
//   S_POWERUP | waiting POWERUP_CYCLES after reset
//   S_INIT    | sending the four init commands, init_idx tracks progress
//   S_IDLE    | ready, busy low, accepting i_start
//   S_ADDR    | sending Set-DDRAM address command
//   S_DATA    | sending the character byte
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 2000000,
    parameter int EN_PULSE_CYCLES   = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_character,
    input  logic [7:0] i_address,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_init_done,
    output logic [7:0] o_LCD_DATA,
    output logic       o_LCD_EN,
    output logic       o_LCD_RS,
    output logic       o_LCD_RW,
    output logic       o_LCD_ON,
    output logic       o_LCD_BLON
);

    localparam int PW = $clog2(POWERUP_CYCLES + 1);
    localparam logic [PW-1:0] PWR_LOAD = PW'(POWERUP_CYCLES - 1);

    lcd_state_e  state_q, state_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic [7:0]  char_q, char_d;
    logic        busy_q, busy_d;
    logic        init_done_q, init_done_d;

    logic        go;
    logic        go_rs;
    logic [7:0]  go_data;
    logic        long_wait;
    logic        xfer_done;
    logic [7:0]  in_ddram;
    logic        addr_hit;

    assign in_ddram  = ddram_addr(i_address);
    assign long_wait = !go_rs && (go_data == CMD_CLEAR);

`ifdef LCD_ADDR_SKIP_EN
    logic [6:0] last_ddram_q, last_ddram_d;
    logic [6:0] shadow_q, shadow_d;
    logic       shadow_vld_q, shadow_vld_d;

    assign addr_hit = shadow_vld_q && (in_ddram[6:0] == shadow_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_ddram_q <= 7'h00;
            shadow_q     <= 7'h00;
            shadow_vld_q <= 1'b0;
        end else begin
            last_ddram_q <= last_ddram_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    always_comb begin
        last_ddram_d = last_ddram_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        if (state_q == S_IDLE && i_start) begin
            last_ddram_d = in_ddram[6:0];
        end
        // The display auto-increments after a data write; 7-bit wrap matches DDRAM.
        if (state_q == S_DATA && xfer_done) begin
            shadow_d     = last_ddram_q + 7'd1;
            shadow_vld_d = 1'b1;
        end
    end
`else
    assign addr_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_POWERUP;
            pwr_cnt_q   <= PWR_LOAD;
            init_idx_q  <= 2'd0;
            char_q      <= 8'h00;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            init_idx_q  <= init_idx_d;
            char_q      <= char_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_POWERUP: if (pwr_cnt_q == '0) state_d = S_INIT;
            S_INIT:    if (xfer_done && init_idx_q == 2'd3) state_d = S_IDLE;
            S_IDLE:    if (i_start) state_d = addr_hit ? S_DATA : S_ADDR;
            S_ADDR:    if (xfer_done) state_d = S_DATA;
            S_DATA:    if (xfer_done) state_d = S_IDLE;
            default:   state_d = S_POWERUP;
        endcase
    end

    always_comb begin
        go          = 1'b0;
        go_rs       = 1'b0;
        go_data     = 8'h00;
        pwr_cnt_d   = pwr_cnt_q;
        init_idx_d  = init_idx_q;
        char_d      = char_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        case (state_q)
            S_POWERUP: begin
                if (pwr_cnt_q == '0) begin
                    go      = 1'b1;
                    go_data = init_cmd(2'd0);
                end else begin
                    pwr_cnt_d = pwr_cnt_q - PW'(1);
                end
            end
            S_INIT: begin
                if (xfer_done) begin
                    if (init_idx_q == 2'd3) begin
                        busy_d      = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        go         = 1'b1;
                        go_data    = init_cmd(init_idx_q + 2'd1);
                    end
                end
            end
            S_IDLE: begin
                if (i_start) begin
                    char_d = i_character;
                    busy_d = 1'b1;
                    go     = 1'b1;
                    if (addr_hit) begin
                        go_rs   = 1'b1;
                        go_data = i_character;
                    end else begin
                        go_data = CMD_SET_DDRAM | in_ddram;
                    end
                end
            end
            S_ADDR: begin
                if (xfer_done) begin
                    go      = 1'b1;
                    go_rs   = 1'b1;
                    go_data = char_q;
                end
            end
            S_DATA: begin
                if (xfer_done) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    lcd_byte_xfer #(
        .EN_PULSE_CYCLES  (EN_PULSE_CYCLES),
        .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
    ) u_xfer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_go       (go),
        .i_rs       (go_rs),
        .i_data     (go_data),
        .i_long_wait(long_wait),
        .o_done     (xfer_done),
        .o_en       (o_LCD_EN),
        .o_rs       (o_LCD_RS),
        .o_data     (o_LCD_DATA)
    );

    assign o_busy      = busy_q;
    assign o_init_done = init_done_q;
    assign o_LCD_RW    = 1'b0;
    assign o_LCD_ON    = 1'b1;
    assign o_LCD_BLON  = 1'b1;

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller: bus strobes captured on EN rise and compared with a byte-list model.
module tb_lcd_controller;

    localparam int EN_P  = 2;
    localparam int CMD_W = 4;
    localparam int CLR_W = 8;
    localparam int PWR   = 10;
    localparam int T     = 2 * EN_P + CMD_W;
`ifdef LCD_ADDR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start = 1'b0;
    logic [7:0] i_character = 8'h00;
    logic [7:0] i_address = 8'h00;
    logic       o_busy, o_init_done, o_LCD_EN, o_LCD_RS, o_LCD_RW, o_LCD_ON, o_LCD_BLON;
    logic [7:0] o_LCD_DATA;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic en_prev = 1'b0;
    logic [8:0] mon_q[$];
    int         rise_q[$];
    logic [8:0] exp_q[$];
    bit         m_valid = 1'b0;
    int         m_next = 0;

    lcd_controller #(
        .POWERUP_CYCLES   (PWR),
        .EN_PULSE_CYCLES  (EN_P),
        .CMD_WAIT_CYCLES  (CMD_W),
        .CLEAR_WAIT_CYCLES(CLR_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_character(i_character),
        .i_address  (i_address),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_init_done(o_init_done),
        .o_LCD_DATA (o_LCD_DATA),
        .o_LCD_EN   (o_LCD_EN),
        .o_LCD_RS   (o_LCD_RS),
        .o_LCD_RW   (o_LCD_RW),
        .o_LCD_ON   (o_LCD_ON),
        .o_LCD_BLON (o_LCD_BLON)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_LCD_EN === 1'b1 && en_prev === 1'b0) begin
            mon_q.push_back({o_LCD_RS, o_LCD_DATA});
            rise_q.push_back(cyc);
        end
        en_prev <= o_LCD_EN;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected bus bytes for one write, from the display's cursor rules.
    task automatic model_write(input logic [7:0] ch, input logic [7:0] ad);
        int dd;
        dd = (ad[4] ? 64 : 0) + int'(ad[3:0]);
        if (!(SKIP && m_valid && dd == m_next))
            exp_q.push_back({1'b0, 8'(128 + dd)});
        exp_q.push_back({1'b1, ch});
        m_next  = (dd + 1) % 128;
        m_valid = 1'b1;
    endtask

    task automatic check_init(input string name);
        logic [8:0] init_exp[4];
        int k;
        init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006};
        k = 0;
        while (o_busy === 1'b1 && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        n_cmp++;
        if (k >= 500) begin
            n_bad++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, o_busy, k);
        end
        n_cmp++;
        if (o_init_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: init_done=%b required 1", name, o_init_done);
        end
        n_cmp++;
        if (mon_q.size() != 4) begin
            n_bad++;
            $display("FAIL %s_count: %0d strobes, required 4", name, mon_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (mon_q[i] !== init_exp[i]) begin
                    n_bad++;
                    $display("FAIL %s_byte%0d: rs/data=%h required %h", name, i, mon_q[i], init_exp[i]);
                end
            end
            n_cmp++;
            if (rise_q[1] - rise_q[0] != T || rise_q[2] - rise_q[1] != T ||
                rise_q[3] - rise_q[2] != 2 * EN_P + CLR_W) begin
                n_bad++;
                $display("FAIL %s_gaps: %0d %0d %0d required %0d %0d %0d", name,
                         rise_q[1] - rise_q[0], rise_q[2] - rise_q[1], rise_q[3] - rise_q[2],
                         T, T, 2 * EN_P + CLR_W);
            end
        end
        m_valid = 1'b0;
    endtask

    task automatic run_write(input logic [7:0] ch, input logic [7:0] ad, input int repulse,
                             input string name);
        int busy_cnt;
        exp_q.delete();
        mon_q.delete();
        rise_q.delete();
        model_write(ch, ad);
        @(negedge i_clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_ready: busy=%b required 0", name, o_busy);
        end
        i_character = ch;
        i_address   = ad;
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        busy_cnt = 0;
        while (o_busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (busy_cnt == repulse) begin
                i_start     = 1'b1;
                i_character = 8'h5A;
                i_address   = 8'h1F;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        n_cmp++;
        if (busy_cnt != exp_q.size() * T) begin
            n_bad++;
            $display("FAIL %s_busy_len: %0d cycles, required %0d", name, busy_cnt, exp_q.size() * T);
        end
        n_cmp++;
        if (mon_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s_count: %0d strobes, required %0d", name, mon_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (mon_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL %s_byte%0d: rs/data=%h required %h", name, i, mon_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        n_cmp++; if (o_LCD_DATA !== 8'h00) begin n_bad++; $display("FAIL rst_data: %h required 00", o_LCD_DATA); end
        n_cmp++; if (o_LCD_EN !== 1'b0) begin n_bad++; $display("FAIL rst_en: %b required 0", o_LCD_EN); end
        n_cmp++; if (o_LCD_RS !== 1'b0) begin n_bad++; $display("FAIL rst_rs: %b required 0", o_LCD_RS); end
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: %b required 1", o_busy); end
        n_cmp++; if (o_init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: %b required 0", o_init_done); end
        n_cmp++;
        if ({o_LCD_RW, o_LCD_ON, o_LCD_BLON} !== 3'b011) begin
            n_bad++;
            $display("FAIL rst_const: rw/on/blon=%b required 011", {o_LCD_RW, o_LCD_ON, o_LCD_BLON});
        end
        mon_q.delete();
        rise_q.delete();
        i_rst = 1'b0;
        check_init("init");
    endtask

    task automatic test_addr_cases();
        run_write(8'h41, 8'h05, 0, "w05");
        run_write(8'h30, 8'h13, 0, "w13");
        run_write(8'h42, 8'hE2, 0, "wE2");
    endtask

    task automatic test_ignored_start();
        run_write(8'h55, 8'h18, 3, "ign");
        repeat (2 * T) @(negedge i_clk);
        n_cmp++;
        if (mon_q.size() != exp_q.size() || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_extra: %0d strobes busy=%b, required %0d busy=0",
                     mon_q.size(), o_busy, exp_q.size());
        end
    endtask

    task automatic test_skip();
        run_write(8'h61, 8'h05, 0, "sk05");
        run_write(8'h62, 8'h06, 0, "sk06");
        run_write(8'h63, 8'h0F, 0, "sk0F");
        run_write(8'h64, 8'h10, 0, "sk10");
    endtask

    task automatic test_random();
        logic [7:0] ch, ad;
        for (int i = 0; i < 10; i++) begin
            ch = 8'($urandom);
            ad = 8'($urandom);
            if ($urandom_range(1) == 1) begin
                if (m_next < 16) ad = {ad[7:5], 5'(m_next)};
                else if (m_next >= 64 && m_next < 80) ad = {ad[7:5], 1'b1, 4'(m_next - 64)};
            end
            run_write(ch, ad, 0, "rnd");
        end
    endtask

    task automatic test_reset_mid();
        int k;
        @(negedge i_clk);
        i_character = 8'h41;
        i_address   = 8'h07;
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        k = 0;
        while (!(o_LCD_EN === 1'b1 && o_LCD_RS === 1'b1) && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_bad++;
            $display("FAIL mid_find_pulse: no data pulse after %0d cycles", k);
        end
        #1 i_rst = 1'b1;
        #1;
        n_cmp++;
        if (o_LCD_EN !== 1'b0 || o_busy !== 1'b1 || o_init_done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: en/busy/init_done=%b%b%b required 010", o_LCD_EN, o_busy, o_init_done);
        end
        @(negedge i_clk);
        mon_q.delete();
        rise_q.delete();
        i_rst = 1'b0;
        check_init("reinit");
    endtask

    initial begin
        test_reset();
        test_addr_cases();
        test_ignored_start();
        test_skip();
        test_random();
        test_reset_mid();
        test_skip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
